fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/ifid_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage: NOP/HALT encodings,
// the fetch FSM state type and the default reset PC.
package fetch_unit_pkg;

  localparam logic [15:0] NopInstr       = 16'h0800;
  localparam logic [4:0]  HaltOpcode     = 5'b00000;
  localparam logic [15:0] DefaultResetPc = 16'h0000;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StHold   = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == HaltOpcode;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; otherwise a bubble is inserted.
module ifid_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_plus2_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_plus2_o,
  output logic        valid_o
);

  logic [15:0] instr_q, pc_plus2_q;
  logic        valid_q;

  // A bubble or flush only kills the instruction; pc_plus2 keeps its last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= NopInstr;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus2_q <= pc_plus2_i;
      valid_q    <= 1'b1;
    end else if (!stall_i) begin
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch stage with a one-entry stall buffer,
// redirect/kill handling for in-flight requests, HALT detection and a sticky fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  input  logic        imem_err,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halt,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  pending_pc_q, pending_pc_d;
  logic [15:0]  hold_buf_q, hold_buf_d;
  logic         kill_q, kill_d;
  logic         err_q, err_d;

  logic         ifid_load, ifid_flush;
  logic [15:0]  ifid_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      pending_pc_q <= 16'h0000;
      hold_buf_q   <= 16'h0000;
      kill_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      hold_buf_q   <= hold_buf_d;
      kill_q       <= kill_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    hold_buf_d   = hold_buf_q;
    kill_d       = kill_q;
    err_d        = err_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_word    = imem_rdata;

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_d   = redirect_pc;
            kill_d = 1'b0;
          end else begin
            // The request cannot be cancelled; remember the target and drop its reply.
            kill_d       = 1'b1;
            pending_pc_d = redirect_pc;
          end
        end else if (imem_ready) begin
          if (kill_q) begin
            pc_d   = pending_pc_q;
            kill_d = 1'b0;
          end else if (imem_err) begin
            err_d   = 1'b1;
            state_d = StHalted;
          end else if (stall) begin
            hold_buf_d = imem_rdata;
            state_d    = StHold;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + 16'd2;
            if (is_halt(imem_rdata)) state_d = StHalted;
          end
        end
      end
      StHold: begin
        ifid_word = hold_buf_q;
        if (redirect) begin
          ifid_flush = 1'b1;
          hold_buf_d = 16'h0000;
          pc_d       = redirect_pc;
          state_d    = StFetch;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          hold_buf_d = 16'h0000;
          pc_d       = pc_q + 16'd2;
          state_d    = is_halt(hold_buf_q) ? StHalted : StFetch;
        end
      end
      StHalted: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          // A memory fault is terminal; only reset leaves HALTED then.
          if (!err_q) begin
            pc_d    = redirect_pc;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StFetch;
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (ifid_load),
    .stall_i    (stall),
    .flush_i    (ifid_flush),
    .instr_i    (ifid_word),
    .pc_plus2_i (pc_q + 16'd2),
    .instr_o    (instr_out),
    .pc_plus2_o (pc_plus2),
    .valid_o    (instr_valid)
  );

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign halt      = (state_q == StHalted);
  assign err       = err_q;

endmodule
